// File: rtl/ibus_dbus_arbiter.sv
// ibus_dbus_arbiter
//   Shares the core's single memory port between the instruction-fetch bus
//   and the data bus. It keeps at most one single-beat transaction in flight
//   and sends the response back to the requester that owns it. Data requests
//   have priority. A saturating counter of consecutive data grants makes sure
//   a pending instruction fetch is served after at most DMAX data grants.
//
// Parameters
//   DMAX : data grants allowed in a row while a fetch is waiting (1..15)
//   AW   : address width
//
// Ports
//   clk, reset (async, active-low)
//   ireq_* / iresp_* : instruction requester (valid held until data_ok)
//   dreq_* / dresp_* : data requester (valid held until data_ok)
//   mreq_*           : memory request. Driven only from registered fields.
//   mresp_*          : memory completion pulse and read data
module ibus_dbus_arbiter #(
  parameter int DMAX = 4,
  parameter int AW   = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq_valid,
  input  logic [AW-1:0] ireq_addr,
  output logic          iresp_addr_ok,
  output logic          iresp_data_ok,
  output logic [31:0]   iresp_data,
  input  logic          dreq_valid,
  input  logic [AW-1:0] dreq_addr,
  input  logic [2:0]    dreq_size,
  input  logic [7:0]    dreq_strobe,
  input  logic [63:0]   dreq_data,
  output logic          dresp_addr_ok,
  output logic          dresp_data_ok,
  output logic [63:0]   dresp_data,
  output logic          mreq_valid,
  output logic [AW-1:0] mreq_addr,
  output logic [2:0]    mreq_size,
  output logic [7:0]    mreq_strobe,
  output logic [63:0]   mreq_data,
  input  logic          mresp_ready,
  input  logic [63:0]   mresp_data
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} st_t;

  localparam logic [3:0] DMAX_C = 4'(DMAX);

  st_t           st_q, st_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    strobe_q, strobe_d;
  logic [63:0]   wdata_q, wdata_d;
  // High only in the first cycle of a transaction. It drives the addr_ok pulse.
  logic          aok_q, aok_d;

  // Next-state, arbitration and capture of the request fields
  always_comb begin
    st_d     = st_q;
    dcnt_d   = dcnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    aok_d    = 1'b0;
    case (st_q)
      IDLE: begin
        if (dreq_valid && !(ireq_valid && dcnt_q == DMAX_C)) begin
          st_d     = DBUSY;
          addr_d   = dreq_addr;
          size_d   = dreq_size;
          strobe_d = dreq_strobe;
          wdata_d  = dreq_data;
          aok_d    = 1'b1;
          // Count only data grants that pass over a waiting fetch.
          if (!ireq_valid)            dcnt_d = 4'd0;
          else if (dcnt_q < DMAX_C)   dcnt_d = dcnt_q + 4'd1;
        end else if (ireq_valid) begin
          st_d     = IBUSY;
          addr_d   = ireq_addr;
          size_d   = 3'd2;
          strobe_d = 8'h00;
          wdata_d  = 64'h0;
          aok_d    = 1'b1;
          dcnt_d   = 4'd0;
        end
      end
      IBUSY, DBUSY: begin
        if (mresp_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= IDLE;
      dcnt_q   <= 4'd0;
      addr_q   <= '0;
      size_q   <= 3'd0;
      strobe_q <= 8'h00;
      wdata_q  <= 64'h0;
      aok_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      dcnt_q   <= dcnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      aok_q    <= aok_d;
    end
  end

  // Outputs depend only on registered state and the memory response.
  // In IDLE every output is forced to zero.
  always_comb begin
    mreq_valid    = 1'b0;
    mreq_addr     = '0;
    mreq_size     = 3'd0;
    mreq_strobe   = 8'h00;
    mreq_data     = 64'h0;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'h0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
    if (st_q != IDLE) begin
      mreq_valid  = 1'b1;
      mreq_addr   = addr_q;
      mreq_size   = size_q;
      mreq_strobe = strobe_q;
      mreq_data   = wdata_q;
    end
    if (st_q == IBUSY) begin
      iresp_addr_ok = aok_q;
      iresp_data_ok = mresp_ready;
      if (mresp_ready) iresp_data = addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
    end
    if (st_q == DBUSY) begin
      dresp_addr_ok = aok_q;
      dresp_data_ok = mresp_ready;
      if (mresp_ready) dresp_data = mresp_data;
    end
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
module tb_ibus_dbus_arbiter;
  localparam int AW   = 64;
  localparam int DMAX = 4;

  logic          clk;
  logic          rst_n;
  logic          ireq_valid;
  logic [AW-1:0] ireq_addr;
  logic          iresp_addr_ok, iresp_data_ok;
  logic [31:0]   iresp_data;
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok, dresp_data_ok;
  logic [63:0]   dresp_data;
  logic          mreq_valid;
  logic [AW-1:0] mreq_addr;
  logic [2:0]    mreq_size;
  logic [7:0]    mreq_strobe;
  logic [63:0]   mreq_data;
  logic          mresp_ready;
  logic [63:0]   mresp_data;

  ibus_dbus_arbiter #(.DMAX(DMAX), .AW(AW)) dut (
    .clk(clk), .reset(rst_n),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_ready(mresp_ready), .mresp_data(mresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_i;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } req_t;
  typedef struct {
    bit          is_i;
    logic [63:0] data;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Transaction-level reference: who owns the port, how many data grants in a row
  bit   m_busy, m_own_i, m_a2;
  int   m_cnt;
  bit   glog[$];
  // Requester state: 0 idle, 1 waiting, 2 granted, 3 flushed while in flight
  int   i_st, d_st;
  int   bc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at the negedge after the inputs are set: queue the response the
  // owner should see in this cycle.
  task automatic apply();
    rsp_t r;
    if (mresp_ready && m_busy) begin
      r.is_i = m_own_i;
      if (m_own_i) r.data = {32'h0, (m_a2 ? mresp_data[63:32] : mresp_data[31:0])};
      else         r.data = mresp_data;
      rsp_q.push_back(r);
    end
  endtask

  task automatic model_update();
    req_t e;
    if (!m_busy) begin
      if (dreq_valid && !(ireq_valid && m_cnt == DMAX)) begin
        e.is_i = 1'b0; e.addr = dreq_addr; e.size = dreq_size;
        e.strobe = dreq_strobe; e.data = dreq_data;
        req_q.push_back(e);
        if (!ireq_valid) m_cnt = 0;
        else if (m_cnt < DMAX) m_cnt++;
        m_busy = 1'b1; m_own_i = 1'b0; glog.push_back(1'b0);
        if (d_st == 1) d_st = 2;
      end else if (ireq_valid) begin
        e.is_i = 1'b1; e.addr = ireq_addr; e.size = 3'd2; e.strobe = 8'h00; e.data = 64'h0;
        req_q.push_back(e);
        m_cnt = 0; m_busy = 1'b1; m_own_i = 1'b1; m_a2 = ireq_addr[2];
        glog.push_back(1'b1);
        if (i_st == 1) i_st = 2;
      end
    end else if (mresp_ready) begin
      m_busy = 1'b0;
      if (m_own_i) i_st = 0; else d_st = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic cyc();
    apply();
    step();
  endtask

  task automatic req_tick(input bit allow_new, input int pct, input bit chaos);
    if (i_st == 0) begin
      ireq_valid = 1'b0;
      if (allow_new && int'($urandom_range(0, 99)) < pct) begin
        ireq_valid = 1'b1;
        ireq_addr  = {$urandom, $urandom} & ~64'h3;
        i_st = 1;
      end
    end else if (chaos && i_st >= 2) begin
      if ($urandom_range(0, 3) == 0) ireq_addr = {$urandom, $urandom} & ~64'h3;
      if (i_st == 2 && $urandom_range(0, 19) == 0) begin ireq_valid = 1'b0; i_st = 3; end
    end
    if (d_st == 0) begin
      dreq_valid = 1'b0;
      if (allow_new && int'($urandom_range(0, 99)) < pct) begin
        dreq_valid  = 1'b1;
        dreq_addr   = {$urandom, $urandom};
        dreq_size   = 3'($urandom_range(0, 3));
        dreq_strobe = 8'($urandom);
        dreq_data   = {$urandom, $urandom};
        d_st = 1;
      end
    end else if (chaos && d_st >= 2) begin
      if ($urandom_range(0, 3) == 0) begin
        dreq_addr = {$urandom, $urandom}; dreq_data = {$urandom, $urandom};
        dreq_strobe = 8'($urandom);
      end
      if (d_st == 2 && $urandom_range(0, 19) == 0) begin dreq_valid = 1'b0; d_st = 3; end
    end
  endtask

  // Memory: fixed mode completes on the second busy cycle; random mode also
  // injects stray completion pulses while the port is idle.
  task automatic mem_tick(input bit fixed);
    mresp_data = {$urandom, $urandom};
    if (fixed) begin
      if (m_busy) bc++; else bc = 0;
      mresp_ready = m_busy && bc == 2;
    end else if (m_busy) mresp_ready = ($urandom_range(0, 2) == 0);
    else                 mresp_ready = ($urandom_range(0, 7) == 0);
  endtask

  task automatic mon();
    req_t e;
    rsp_t r;
    chk("mreq_valid", {63'h0, mreq_valid}, {63'h0, m_busy});
    if (!m_busy)
      chk("idle_mreq_fields", mreq_addr | mreq_data | {53'h0, mreq_size, mreq_strobe}, 64'h0);
    chk("dual_addr_ok", {63'h0, iresp_addr_ok & dresp_addr_ok}, 64'h0);
    if (iresp_addr_ok || dresp_addr_ok) begin
      if (req_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_addr_ok actual=1 required=0");
      end else begin
        e = req_q.pop_front();
        chk("addr_ok_owner", {63'h0, iresp_addr_ok}, {63'h0, e.is_i});
        chk("mreq_addr", mreq_addr, e.addr);
        chk("mreq_size", {61'h0, mreq_size}, {61'h0, e.size});
        chk("mreq_strobe", {56'h0, mreq_strobe}, {56'h0, e.strobe});
        chk("mreq_data", mreq_data, e.data);
      end
    end
    if (iresp_data_ok || dresp_data_ok) begin
      chk("addr_ok_pending_at_data_ok", 64'(req_q.size()), 64'h0);
      if (rsp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_data_ok actual=1 required=0");
      end else begin
        r = rsp_q.pop_front();
        chk("data_ok_owner", {63'h0, iresp_data_ok}, {63'h0, r.is_i});
        chk("dual_data_ok", {63'h0, iresp_data_ok & dresp_data_ok}, 64'h0);
        if (r.is_i) begin
          chk("iresp_data", {32'h0, iresp_data}, r.data);
          chk("dresp_data_quiet", dresp_data, 64'h0);
        end else begin
          chk("dresp_data", dresp_data, r.data);
          chk("iresp_data_quiet", {32'h0, iresp_data}, 64'h0);
        end
      end
    end else begin
      chk("resp_data_zero", dresp_data | {32'h0, iresp_data}, 64'h0);
    end
  endtask

  always begin
    @(negedge clk);
    #3;
    if (rst_n) mon();
  end

  task automatic model_reset();
    m_busy = 0; m_own_i = 0; m_a2 = 0; m_cnt = 0; bc = 0;
    i_st = 0; d_st = 0;
    req_q.delete(); rsp_q.delete();
    ireq_valid = 0; dreq_valid = 0; mresp_ready = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    ireq_addr = '0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    mresp_data = '0;
    model_reset();
    #4;
    chk("reset_outputs", {63'h0, mreq_valid | iresp_addr_ok | iresp_data_ok | dresp_addr_ok |
        dresp_data_ok} | mreq_addr | dresp_data, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset while a data transaction is in flight
    dreq_valid = 1; dreq_addr = 64'h8000_0040; dreq_size = 3; dreq_strobe = 8'h0F;
    dreq_data = 64'h1234; d_st = 1;
    cyc();
    #2;
    chk("dbusy_before_reset", {63'h0, mreq_valid}, 64'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_mreq_valid", {63'h0, mreq_valid}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Contention: both requesters always pending, memory answers on the 2nd busy cycle
    glog.delete();
    for (int n = 0; n < 200 && glog.size() < 10; n++) begin
      req_tick(1'b1, 100, 1'b0);
      mem_tick(1'b1);
      cyc();
    end
    chk("contention_grants", 64'(glog.size()), 64'd10);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk("grant_order", {63'h0, glog[k]}, {63'h0, (k == 4 || k == 9) ? 1'b1 : 1'b0});
    for (int n = 0; n < 100 && (i_st != 0 || d_st != 0 || m_busy); n++) begin
      req_tick(1'b0, 0, 1'b0);
      mem_tick(1'b1);
      cyc();
    end
    req_tick(1'b0, 0, 1'b0);
    mresp_ready = 0;
    cyc();

    // Lone instruction fetch from the upper word
    ireq_valid = 1; ireq_addr = 64'h8000_0004; i_st = 1;
    cyc();
    #4;
    chk("ifetch_mreq_valid", {63'h0, mreq_valid}, 64'h1);
    chk("ifetch_mreq_addr", mreq_addr, 64'h8000_0004);
    chk("ifetch_mreq_size", {61'h0, mreq_size}, 64'd2);
    chk("ifetch_mreq_strobe", {56'h0, mreq_strobe}, 64'h0);
    chk("ifetch_addr_ok", {63'h0, iresp_addr_ok}, 64'h1);
    step();
    cyc();
    mresp_ready = 1; mresp_data = 64'h1111_2222_3333_4444;
    apply();
    #4;
    chk("ifetch_data_ok", {63'h0, iresp_data_ok}, 64'h1);
    chk("ifetch_data", {32'h0, iresp_data}, 64'h1111_2222);
    step();
    ireq_valid = 0; mresp_ready = 0;
    apply();
    #4;
    chk("ifetch_done_idle", {63'h0, mreq_valid}, 64'h0);
    step();

    // Store of a full doubleword
    dreq_valid = 1; dreq_addr = 64'h8000_0010; dreq_size = 3; dreq_strobe = 8'hFF;
    dreq_data = 64'hDEAD_BEEF_0000_0001; d_st = 1;
    cyc();
    #4;
    chk("store_mreq_addr", mreq_addr, 64'h8000_0010);
    chk("store_mreq_size", {61'h0, mreq_size}, 64'd3);
    chk("store_mreq_strobe", {56'h0, mreq_strobe}, 64'hFF);
    chk("store_mreq_data", mreq_data, 64'hDEAD_BEEF_0000_0001);
    step();
    mresp_ready = 1; mresp_data = 64'h0;
    apply();
    #4;
    chk("store_data_ok", {63'h0, dresp_data_ok}, 64'h1);
    chk("store_ibus_quiet", {62'h0, iresp_addr_ok, iresp_data_ok}, 64'h0);
    step();
    dreq_valid = 0; mresp_ready = 0;
    cyc();

    // Flush: inputs change and valid drops after the grant
    dreq_valid = 1; dreq_addr = 64'h8000_0020; dreq_size = 3; dreq_strobe = 8'h00; d_st = 1;
    cyc();
    dreq_valid = 0; dreq_addr = 64'h0; d_st = 3;
    apply();
    #4;
    chk("flush_mreq_addr", mreq_addr, 64'h8000_0020);
    step();
    mresp_ready = 1; mresp_data = 64'hCAFE_F00D_5555_AAAA;
    apply();
    #4;
    chk("flush_data_ok", {63'h0, dresp_data_ok}, 64'h1);
    step();
    mresp_ready = 0;
    apply();
    #4;
    chk("flush_idle", {63'h0, mreq_valid}, 64'h0);
    step();

    // Randomized traffic with flushes, field changes and stray completions
    for (int n = 0; n < 3000; n++) begin
      req_tick(1'b1, 40, 1'b1);
      mem_tick(1'b0);
      cyc();
    end
    for (int n = 0; n < 300 && (i_st != 0 || d_st != 0 || m_busy); n++) begin
      req_tick(1'b0, 0, 1'b1);
      mem_tick(1'b0);
      cyc();
    end
    req_tick(1'b0, 0, 1'b0);
    mresp_ready = 0;
    cyc();
    cyc();
    chk("drain_idle", {63'h0, m_busy}, 64'h0);
    chk("req_queue_empty", 64'(req_q.size()), 64'h0);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibus_dbus_arbiter.md
Name: ibus_dbus_arbiter

Overview:
- Shares the core's single memory port between the fetch-stage instruction bus and the memory-stage data bus.
- Sits between the core and the memory bus interconnect.
- Owns one outstanding single-beat transaction at a time and routes the response back to the owner.
- Data requests have priority. A bounded-starvation counter guarantees instruction fetch progress.

Parameters:
- DMAX, 4: maximum consecutive data grants while an instruction request is pending; range 1..15.
- AW, 64: address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ireq_valid  in  1  instruction request pending; held until iresp_data_ok.
- ireq_addr  in  AW  fetch address, 4-byte aligned.
- iresp_addr_ok  out  1  instruction request accepted by memory.
- iresp_data_ok  out  1  instruction data valid, one-cycle pulse.
- iresp_data  out  32  fetched instruction.
- dreq_valid  in  1  data request pending; held until dresp_data_ok.
- dreq_addr  in  AW  data address.
- dreq_size  in  3  log2 access bytes.
- dreq_strobe  in  8  byte write enables; 0 means read.
- dreq_data  in  64  store data, lane-aligned.
- dresp_addr_ok  out  1  data request accepted.
- dresp_data_ok  out  1  data response valid, one-cycle pulse.
- dresp_data  out  64  load data, lane-aligned.
- mreq_valid  out  1  memory request valid.
- mreq_addr  out  AW  memory address.
- mreq_size  out  3  access size; 3'd2 for instruction fetch.
- mreq_strobe  out  8  byte enables; 0 for instruction fetch.
- mreq_data  out  64  store data; 0 for instruction fetch.
- mresp_ready  in  1  memory transaction complete, one-cycle pulse.
- mresp_data  in  64  memory read data.

Behaviour:
- State register st ∈ {IDLE, IBUSY, DBUSY}.
- Reset (reset=0, asynchronous):
  - st=IDLE, dcnt=0, captured address/fields=0.
  - All outputs 0 while in reset and in IDLE.
- IDLE, arbitration:
  - dreq_valid && !(ireq_valid && dcnt==DMAX) → DBUSY.
  - Else ireq_valid → IBUSY.
  - Else stay IDLE.
- Capture at grant:
  - On the grant edge, register the owner's addr, size, strobe and data.
  - For instruction fetch, register size=2, strobe=0, data=0.
  - Memory sees only registered values. A requester changing its inputs mid-transaction has no effect.
- BUSY, request phase:
  - mreq_valid=1 continuously with the captured fields until mresp_ready.
  - Owner's addr_ok is asserted in the same cycle as mreq_valid's first cycle, as a one-cycle pulse.
- BUSY, completion:
  - mresp_ready=1 → owner's data_ok=1 combinationally in that cycle; st→IDLE next edge. mreq_valid is still 1 in that cycle.
  - Non-owner addr_ok/data_ok stay 0 at all times.
- Response data:
  - iresp_data = captured_addr[2] ? mresp_data[63:32] : mresp_data[31:0].
  - dresp_data = mresp_data.
  - Both are driven only while data_ok is high, 0 otherwise.
- Latency:
  - Request seen in IDLE at cycle 0 → mreq_valid at cycle 1.
  - Completion at cycle k → next grant decided at k+1, next mreq_valid at k+2. There is exactly one IDLE bubble between transactions.
- Starvation counter dcnt (4 bits):
  - Data grant while ireq_valid=1 → dcnt+1, saturating at DMAX.
  - Any instruction grant → dcnt=0.
  - Data grant with ireq_valid=0 → dcnt=0.
- Simultaneous events:
  - Both valid in IDLE with dcnt<DMAX → data wins.
  - Both valid with dcnt==DMAX → instruction wins.
- Requester drops valid mid-transaction (flush):
  - The memory transaction still completes and data_ok still pulses.
  - The requester ignores it; the arbiter never aborts.
- mresp_ready in IDLE is ignored and generates no pulses.
- Reset mid-transaction: immediate return to IDLE with outputs 0. The pending memory transaction is abandoned; the memory side is reset by the same signal.
- No combinational path from ireq_*/dreq_* to mreq_*.

Test Plan:
- Reset asserted in DBUSY with mreq_valid=1 → mreq_valid=0 asynchronously (before next clk edge); after release, st=IDLE, dcnt=0.
- Lone ifetch: ireq_valid=1, addr=0x8000_0004 at cycle 0 → cycle 1 mreq_valid=1, addr=0x8000_0004, size=2, strobe=0, iresp_addr_ok=1. Cycle 3 mresp_ready=1, mresp_data=0x1111_2222_3333_4444 → iresp_data_ok=1, iresp_data=0x1111_2222. Cycle 4 mreq_valid=0.
- Store: dreq addr=0x8000_0010, size=3, strobe=0xFF, data=0xDEAD_BEEF_0000_0001, completion after 1 cycle → mreq fields match exactly; dresp_data_ok pulses once; iresp_* stay 0 throughout.
- Contention, DMAX=4: ireq_valid and dreq_valid held high, memory completes every grant after 2 cycles → grant order D,D,D,D,I,D,D,D,D,I; dcnt returns to 0 after each I.
- Mid-flight input change/flush: after dreq grant, change dreq_addr to 0x0 and drop dreq_valid → mreq_addr remains the original address; dresp_data_ok still pulses on mresp_ready; next cycle IDLE.
